// File: rtl/serpent_pkg.sv
// Serpent S-box tables and lookup helpers shared by the S-box layer.
// Tables are packed nibble strings: nibble n of entry s is S_s(n).
package serpent_pkg;

    typedef logic [2:0]        sbox_sel_t;
    typedef logic [7:0][63:0]  sbox_tab_t;

    localparam sbox_tab_t SBOX_FWD = {
        64'h6539_AC47_B28E_0FD1,   // S7
        64'h0A3D_F19E_B648_5C27,   // S6
        64'h176D_8E30_C9A4_B25F,   // S5
        64'hD7E9_A452_6B0C_38F1,   // S4
        64'hE57A_421D_369C_8BF0,   // S3
        64'h25B0_4E1D_FAC3_9768,   // S2
        64'h43D6_8EB1_A509_72CF,   // S1
        64'hC907_24DE_B56A_1F83    // S0
    };

    function automatic logic sbox_is_bijection(int s);
        logic [15:0] seen;
        logic [3:0]  f;
        seen = '0;
        for (int n = 0; n < 16; n++) begin
            f = SBOX_FWD[s][n*4 +: 4];
            seen[f] = 1'b1;
        end
        return &seen;
    endfunction

    function automatic sbox_tab_t build_inv_tab();
        sbox_tab_t  t;
        logic [3:0] f;
        t = '0;
        for (int s = 0; s < 8; s++) begin
            for (int n = 0; n < 16; n++) begin
                f = SBOX_FWD[s][n*4 +: 4];
                t[s][f*4 +: 4] = 4'(n);
            end
        end
        return t;
    endfunction

    localparam sbox_tab_t SBOX_INV = build_inv_tab();

    function automatic logic [3:0] sbox_fwd(sbox_sel_t idx, logic [3:0] nib);
        return SBOX_FWD[idx][{nib, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(sbox_sel_t idx, logic [3:0] nib);
        return SBOX_INV[idx][{nib, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/serpent_sbox_pipe_if.sv
// Valid/ready bundle for the S-box layer: request side, result side and busy flag.
interface serpent_sbox_pipe_if
    import serpent_pkg::*;
#(
    parameter int LANES = 32,
    parameter int TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    sbox_sel_t         in_sel;
    logic              in_inv;
    logic [TAG_W-1:0]  in_tag;
    logic [LANES-1:0]  in_x0, in_x1, in_x2, in_x3;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [LANES-1:0]  out_y0, out_y1, out_y2, out_y3;
    logic              busy;

    modport slave (
        input  in_valid, in_sel, in_inv, in_tag, in_x0, in_x1, in_x2, in_x3, out_ready,
        output in_ready, out_valid, out_tag, out_y0, out_y1, out_y2, out_y3, busy
    );

    modport master (
        output in_valid, in_sel, in_inv, in_tag, in_x0, in_x1, in_x2, in_x3, out_ready,
        input  in_ready, out_valid, out_tag, out_y0, out_y1, out_y2, out_y3, busy
    );
endinterface

// File: rtl/serpent_sbox_lanes.sv
// Combinational bitsliced S-box: LANES independent 4-bit lookups sharing one sel/inv.
module serpent_sbox_lanes
    import serpent_pkg::*;
#(
    parameter int LANES = 32
) (
    input  sbox_sel_t         sel,
    input  logic              inv,
    input  logic [LANES-1:0]  x0,
    input  logic [LANES-1:0]  x1,
    input  logic [LANES-1:0]  x2,
    input  logic [LANES-1:0]  x3,
    output logic [LANES-1:0]  y0,
    output logic [LANES-1:0]  y1,
    output logic [LANES-1:0]  y2,
    output logic [LANES-1:0]  y3
);
    // A non-bijective table would make the derived inverse silently wrong.
    for (genvar gi = 0; gi < 8; gi++) begin : g_check
        if (!sbox_is_bijection(gi)) begin : g_bad
            $error("serpent_sbox_lanes: forward S-box %0d is not a bijection", gi);
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [3:0] nib;
        logic [3:0] res;
        assign nib    = {x3[gi], x2[gi], x1[gi], x0[gi]};
        assign res    = inv ? sbox_inv(sel, nib) : sbox_fwd(sel, nib);
        assign y0[gi] = res[0];
        assign y1[gi] = res[1];
        assign y2[gi] = res[2];
        assign y3[gi] = res[3];
    end
endmodule

// File: rtl/serpent_sbox_pipe.sv
// Elastic S-box layer: S-box ahead of stage 1, then STAGES-1 delay stages, no-bubble valid/ready.
module serpent_sbox_pipe
    import serpent_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serpent_sbox_pipe_if.slave  bus
);
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("serpent_sbox_pipe: STAGES must be 1..3");
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [LANES-1:0] y3;
        logic [LANES-1:0] y2;
        logic [LANES-1:0] y1;
        logic [LANES-1:0] y0;
    } stage_t;

    stage_t sbox_out;
    logic   v_q    [STAGES];
    logic   v_d    [STAGES];
    stage_t data_q [STAGES];
    stage_t data_d [STAGES];
    logic   load   [STAGES];
    logic   busy_c;

    serpent_sbox_lanes #(.LANES(LANES)) u_lanes (
        .sel (bus.in_sel),
        .inv (bus.in_inv),
        .x0  (bus.in_x0),
        .x1  (bus.in_x1),
        .x2  (bus.in_x2),
        .x3  (bus.in_x3),
        .y0  (sbox_out.y0),
        .y1  (sbox_out.y1),
        .y2  (sbox_out.y2),
        .y3  (sbox_out.y3)
    );
    assign sbox_out.tag = bus.in_tag;

    // A stage may load when it is empty or everything downstream of it is moving.
    always_comb begin
        logic r;
        r = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r       = !v_q[k] || r;
            load[k] = r;
        end
    end

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy_c = busy_c | v_q[k];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic   up_v;
        stage_t up_data;

        if (gi == 0) begin : g_head
            assign up_v    = bus.in_valid;
            assign up_data = sbox_out;
        end else begin : g_body
            assign up_v    = v_q[gi-1];
            assign up_data = data_q[gi-1];
        end

        // Payload only moves with a valid beat so idle-time input garbage never lands in a register.
        always_comb begin
            v_d[gi]    = v_q[gi];
            data_d[gi] = data_q[gi];
            if (load[gi]) begin
                v_d[gi] = up_v;
                if (up_v) begin
                    data_d[gi] = up_data;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[gi]    <= 1'b0;
                data_q[gi] <= '0;
            end else begin
                v_q[gi]    <= v_d[gi];
                data_q[gi] <= data_d[gi];
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_tag   = data_q[STAGES-1].tag;
    assign bus.out_y0    = data_q[STAGES-1].y0;
    assign bus.out_y1    = data_q[STAGES-1].y1;
    assign bus.out_y2    = data_q[STAGES-1].y2;
    assign bus.out_y3    = data_q[STAGES-1].y3;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_serpent_sbox_pipe.sv
// Self-checking bench for serpent_sbox_pipe: queue-based reference model plus directed literal checks.
module tb_serpent_sbox_pipe;
    localparam int LANES  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serpent_sbox_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    serpent_sbox_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int FWD [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    typedef struct {
        logic [127:0]     y;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t         q [$];
    int           seen_tags [$];
    logic [127:0] last_y;
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    bit           rand_en;
    bit           ready_force;

    function automatic int mfwd(int s, int n);
        return FWD[s][n];
    endfunction

    function automatic int minv(int s, int n);
        for (int v = 0; v < 16; v++) if (FWD[s][v] == n) return v;
        return -1;
    endfunction

    // Result packed as {y3,y2,y1,y0}.
    function automatic logic [127:0] model(int s, bit inv, logic [31:0] x0, logic [31:0] x1,
                                           logic [31:0] x2, logic [31:0] x3);
        logic [127:0] r;
        int n, o;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            n = int'({x3[i], x2[i], x1[i], x0[i]});
            o = inv ? minv(s, n) : mfwd(s, n);
            r[i]      = o[0];
            r[32 + i] = o[1];
            r[64 + i] = o[2];
            r[96 + i] = o[3];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_en ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Reference model: in-flight queue in acceptance order, head visible once it is STAGES cycles old.
    initial forever begin
        exp_t e;
        bit   exp_ov;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_busy", bus.busy, 0);
        end else begin
            exp_ov = (q.size() > 0) && (q[0].cyc + STAGES <= cyc);
            chk("in_ready", bus.in_ready, bus.out_ready || (q.size() < STAGES));
            chk("busy", bus.busy, q.size() > 0);
            chk("out_valid", bus.out_valid, exp_ov);
            if (bus.out_valid && q.size() > 0) begin
                chk("out_y", {bus.out_y3, bus.out_y2, bus.out_y1, bus.out_y0}, q[0].y);
                chk("out_tag", bus.out_tag, q[0].tag);
                if (bus.out_ready) begin
                    last_y = {bus.out_y3, bus.out_y2, bus.out_y1, bus.out_y0};
                    seen_tags.push_back(int'(bus.out_tag));
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.y   = model(int'(bus.in_sel), bus.in_inv, bus.in_x0, bus.in_x1, bus.in_x2, bus.in_x3);
                e.tag = bus.in_tag;
                e.cyc = cyc;
                q.push_back(e);
                $display("accept tag=%0d sel=%0d inv=%0d x0=%h", bus.in_tag, bus.in_sel, bus.in_inv, bus.in_x0);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 right after the accepting edge with in_valid still high.
    task automatic send(input int s, input bit inv, input logic [31:0] x0, input logic [31:0] x1,
                        input logic [31:0] x2, input logic [31:0] x3, input int tag);
        int n;
        bus.in_valid = 1'b1;
        bus.in_sel   = s[2:0];
        bus.in_inv   = inv;
        bus.in_tag   = tag[TAG_W-1:0];
        bus.in_x0 = x0; bus.in_x1 = x1; bus.in_x2 = x2; bus.in_x3 = x3;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sel   = 3'($urandom);
        bus.in_inv   = 1'($urandom);
        bus.in_tag   = TAG_W'($urandom);
        bus.in_x0 = $urandom; bus.in_x1 = $urandom; bus.in_x2 = $urandom; bus.in_x3 = $urandom;
    endtask

    task automatic wait_drain(input int n);
        int t;
        t = 0;
        while (seen_tags.size() < n && t < 2000) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("drain_count", seen_tags.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx0, rx1, rx2, rx3;
        logic [127:0] fy;
        int nxt, acc, g, n, sent;

        rst_n = 1'b0; rand_en = 1'b0; ready_force = 1'b1;
        idle();

        chk("model_S0_0", mfwd(0, 0), 3);
        chk("model_S1_F", mfwd(1, 15), 4);
        chk("model_S3_0", mfwd(3, 0), 0);
        chk("model_S0inv_3", minv(0, 3), 0);
        chk("model_S7_9", mfwd(7, 9), 4);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_out_tag", bus.out_tag, 0);
        chk("reset_out_y", {bus.out_y3, bus.out_y2, bus.out_y1, bus.out_y0}, 0);
        @(posedge clk); #1;

        seen_tags.delete();
        send(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1); idle(); wait_drain(1);
        chk("S0_fwd_zero", last_y, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        seen_tags.delete();
        send(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 2); idle(); wait_drain(1);
        chk("S0_inv_three", last_y, 128'h0);
        seen_tags.delete();
        send(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3); idle(); wait_drain(1);
        chk("S1_fwd_F", last_y, {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0});
        seen_tags.delete();
        send(3, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4); idle(); wait_drain(1);
        chk("S3_fwd_zero", last_y, 128'h0);

        // Lane i carries nibble i mod 16; forward then inverse must restore it.
        for (int i = 0; i < LANES; i++) begin
            rx0[i] = i[0]; rx1[i] = i[1]; rx2[i] = i[2]; rx3[i] = i[3];
        end
        for (int s = 0; s < 8; s++) begin
            seen_tags.delete();
            send(s, 0, rx0, rx1, rx2, rx3, s); idle(); wait_drain(1);
            fy = last_y;
            seen_tags.delete();
            send(s, 1, fy[31:0], fy[63:32], fy[95:64], fy[127:96], s + 8); idle(); wait_drain(1);
            chk("roundtrip", last_y, {rx3, rx2, rx1, rx0});
        end

        // Backpressure: 5 back-to-back with out_ready held low for 6 cycles.
        seen_tags.delete();
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nxt = 0; acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = 1'b1; bus.in_sel = 3'(nxt); bus.in_inv = 1'b0; bus.in_tag = TAG_W'(nxt);
            bus.in_x0 = 32'h1111_1111 * nxt; bus.in_x1 = ~bus.in_x0; bus.in_x2 = 32'hA5A5_0F0F; bus.in_x3 = 32'(nxt);
            @(negedge clk);
            if (bus.in_ready) begin acc++; nxt++; end
            @(posedge clk); #1;
        end
        chk("bp_accepts_before_stall", acc, STAGES);
        ready_force = 1'b1;
        g = 0;
        while (nxt < 5 && g < 50) begin
            bus.in_valid = 1'b1; bus.in_sel = 3'(nxt); bus.in_inv = 1'b0; bus.in_tag = TAG_W'(nxt);
            bus.in_x0 = 32'h1111_1111 * nxt; bus.in_x1 = ~bus.in_x0; bus.in_x2 = 32'hA5A5_0F0F; bus.in_x3 = 32'(nxt);
            @(negedge clk);
            if (bus.in_ready) nxt++;
            @(posedge clk); #1;
            g++;
        end
        idle();
        wait_drain(5);
        for (int i = 0; i < 5 && i < seen_tags.size(); i++) chk("bp_tag_order", seen_tags[i], i);

        // Asynchronous reset with two transactions in flight.
        seen_tags.delete();
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(2, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h3333_CCCC, 1);
        send(5, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_FFFF, 32'h5555_AAAA, 2);
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_out_tag", bus.out_tag, 0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ready_force = 1'b1;
        @(posedge clk); #1;
        send(6, 0, 32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4, 32'hC3D2_E1F0, 5);
        idle();
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("post_reset_latency", n, STAGES);
        wait_drain(1);
        chk("post_reset_no_replay", seen_tags[0], 5);

        // Random valid/ready sweep against the model.
        seen_tags.delete();
        rand_en = 1'b1;
        sent = 0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
            end else begin
                send($urandom_range(0, 7), 1'($urandom), $urandom, $urandom, $urandom, $urandom, t);
                sent++;
            end
        end
        idle();
        rand_en = 1'b0;
        ready_force = 1'b1;
        wait_drain(sent);
        repeat (3) @(posedge clk);
        chk("random_no_dup", seen_tags.size(), sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
